// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, addresses instruction memory and buffers
// fetched words in a small FIFO toward decode. Optional JAL prediction: FETCH_JAL_PREDICT_EN.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] pc,
    input  logic [31:0] inst_in,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic        out_pred_taken
);
    localparam int          AW       = $clog2(QDEPTH);
    localparam logic [AW:0] CNT_FULL = (AW + 1)'(QDEPTH);
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    logic [31:0]   pc_r;
    logic [31:0]   q_pc_r   [QDEPTH];
    logic [31:0]   q_inst_r [QDEPTH];
    logic          q_pred_r [QDEPTH];
    logic [AW-1:0] rd_ptr_r;
    logic [AW-1:0] wr_ptr_r;
    logic [AW:0]   count_r;

    logic          has_head_s;
    logic          pop_s;
    logic          enq_s;
    logic          pred_s;
    logic [31:0]   next_pc_s;

    assign has_head_s = (count_r != {(AW + 1){1'b0}});
    assign pop_s      = has_head_s & out_ready;
    // A full FIFO still accepts a word when decode drains the head in the same cycle.
    assign enq_s      = ~redirect_valid & ((count_r != CNT_FULL) | pop_s);

`ifdef FETCH_JAL_PREDICT_EN
    function automatic logic [31:0] jal_offset(input logic [31:0] i);
        return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    endfunction

    // Next fetch address: follow a JAL target immediately, otherwise fall through.
    always_comb begin
        pred_s    = 1'b0;
        next_pc_s = pc_r + 32'd4;
        if (inst_in[6:0] == 7'b1101111) begin
            pred_s    = 1'b1;
            next_pc_s = pc_r + jal_offset(inst_in);
        end else begin
            pred_s    = 1'b0;
            next_pc_s = pc_r + 32'd4;
        end
    end
`else
    assign pred_s    = 1'b0;
    assign next_pc_s = pc_r + 32'd4;
`endif

    // PC, pointers and occupancy; redirect flushes the queue and restarts fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r     <= RESET_PC;
            rd_ptr_r <= {AW{1'b0}};
            wr_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW + 1){1'b0}};
        end else if (redirect_valid) begin
            pc_r     <= redirect_pc & 32'hFFFF_FFFC;
            rd_ptr_r <= {AW{1'b0}};
            wr_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW + 1){1'b0}};
        end else begin
            if (enq_s) begin
                pc_r     <= next_pc_s;
                wr_ptr_r <= wr_ptr_r + {{(AW - 1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(AW - 1){1'b0}}, 1'b1};
            end
            count_r <= count_r + {{AW{1'b0}}, enq_s} - {{AW{1'b0}}, pop_s};
        end
    end

    // FIFO storage of {pc, instruction, predicted} per entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < QDEPTH; k++) begin
                q_pc_r[k]   <= 32'h0000_0000;
                q_inst_r[k] <= NOP_INST;
                q_pred_r[k] <= 1'b0;
            end
        end else if (enq_s) begin
            q_pc_r[wr_ptr_r]   <= pc_r;
            q_inst_r[wr_ptr_r] <= inst_in;
            q_pred_r[wr_ptr_r] <= pred_s;
        end
    end

    // Head presentation; an empty queue shows a NOP at address zero.
    always_comb begin
        out_inst       = NOP_INST;
        out_pc         = 32'h0000_0000;
        out_pred_taken = 1'b0;
        if (has_head_s) begin
            out_inst       = q_inst_r[rd_ptr_r];
            out_pc         = q_pc_r[rd_ptr_r];
            out_pred_taken = q_pred_r[rd_ptr_r];
        end else begin
            out_inst       = NOP_INST;
            out_pc         = 32'h0000_0000;
            out_pred_taken = 1'b0;
        end
    end

    assign pc        = pc_r;
    assign out_valid = has_head_s;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the RISC-V core. Owns the program counter, drives the byte address to the combinational instruction memory, and captures the returned word into a small FIFO that decouples fetch from decode through a valid/ready handshake. Accepts redirects (taken branches, jumps, traps) from execute. It can optionally predict JAL targets at fetch time.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- QDEPTH, 2, FIFO entries. Must be a power of two and at least 2.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- pc  output  32  fetch byte address to instruction memory. Driven directly from the PC register.
- inst_in  input  32  instruction word returned for `pc` in the same cycle.
- redirect_valid  input  1  a redirect is requested this cycle.
- redirect_pc  input  32  redirect target.
- out_valid  output  1  the FIFO head holds an instruction.
- out_ready  input  1  decode accepts the head this cycle.
- out_inst  output  32  head instruction.
- out_pc  output  32  PC of the head instruction.
- out_pred_taken  output  1  the head was a JAL whose target fetch already followed.

## Operation
- State: PC register, FIFO storage of {pc, inst, pred} per entry, read pointer, write pointer, and `count` (0..QDEPTH).
- pop = out_valid & out_ready.
- enq = !redirect_valid & (count < QDEPTH | pop).
- On enq:
  - The entry {pc, inst_in, pred} is written at the write pointer.
  - PC <= next_pc, where next_pc = pc + 4, or the JAL target when prediction fires.
- When there is no enq and no redirect, PC holds, so the same address is re-presented.
- Count update: count_next = count + enq - pop.
- Pointers wrap modulo QDEPTH.
- Enqueue and pop may occur in the same cycle, including when the FIFO is full; count is then unchanged.
- Redirect has priority over everything else:
  - count, read pointer and write pointer are cleared.
  - PC <= {redirect_pc[31:2], 2'b00}.
  - No enqueue happens that cycle.
  - A pop in the same cycle is still honoured by decode, but the flushed entries are discarded.
- Outputs are driven by the head entry:
  - out_valid = (count != 0).
  - When count = 0: out_inst = 32'h0000_0013 (NOP), out_pc = 0, out_pred_taken = 0.
- PC arithmetic is 32-bit modulo. PC 32'hFFFF_FFFC + 4 wraps to 0.

## Timing
- Reset values: pc = RESET_PC, count = 0, out_valid = 0, out_inst = 32'h0000_0013, out_pc = 0, out_pred_taken = 0.
- Reset mid-operation discards all entries and overrides a redirect in the same cycle.
- Fetch latency: a word at `pc` enqueued at edge N is visible on out_* immediately after edge N (one cycle, pc to out_valid).
- Throughput is one instruction per cycle with out_ready held high.
- After a redirect at edge N, out_valid = 0 until edge N+1 enqueues the target. The target appears after N+1.
- Backpressure: with out_ready = 0, after QDEPTH enqueues `pc` is stable until a pop.
- No combinational path from out_ready or redirect_valid to `pc`. `pc` changes only at clock edges.

## Configuration
Macro: `FETCH_JAL_PREDICT_EN`.
- Defined:
  - JAL is detected as inst_in[6:0] = 7'b1101111.
  - When a JAL is enqueued, next_pc = pc + {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0}, and the entry's pred bit is set to 1.
- Not defined:
  - The pred bit is always 0.
  - next_pc is always pc + 4.
  - No decode logic is synthesised.
- Either way, execute still issues redirects. Under prediction, execute must not redirect a JAL whose out_pred_taken = 1.

## Test plan
- Reset, RESET_PC = 32'h100, out_ready = 1, memory returning sequential words -> out_valid = 0 during reset; then out_pc = 100, 104, 108, … on consecutive cycles, with out_inst matching memory.
- out_ready = 0 for 5 cycles from reset release, QDEPTH = 2 -> entries 100 and 104 are held and pc stays at 108. Raising ready yields 100, 104, 108 back-to-back with no gap or duplicate.
- FIFO full (count = 2) while pop and enqueue occur in the same cycle -> count stays 2 and order is preserved.
- redirect_valid with redirect_pc = 32'h0000_0203 while the FIFO is full and out_ready = 1 -> next cycle pc = 200 and out_valid = 0; the cycle after, out_pc = 200. The old entries never reappear.
- FETCH_JAL_PREDICT_EN, instruction 32'h0100_006F (jal x0, +16) at 0x20 -> the next fetched pc = 0x30, and the entry at 0x20 has out_pred_taken = 1. Without the macro -> next pc = 0x24 and out_pred_taken = 0.
- rst asserted for one cycle with 2 entries queued and a redirect pending -> pc = RESET_PC, out_valid = 0, and the redirect is ignored.
